uart_byte_rx: RTL and testbench
===============================

UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL expose parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), giving clk cycles per UART bit; legal range 8..65535.
REQ-003 The block SHALL have the following ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high; frame is 8N1, LSB first.
- byte_out  output  8  last correctly framed byte; held stable between updates.
- byte_end  output  1  one-cycle pulse marking completion of a valid frame.
- frame_err  output  1  one-cycle pulse on a stop-bit error.

Function
REQ-004 rx SHALL pass through a 2-flop synchronizer, giving rx_s, before any use; both flops reset to 1.
REQ-005 The FSM SHALL use states IDLE, START, DATA, STOP, LOAD, DONE and BREAK, with a bit-period counter and a 3-bit data-bit index.
REQ-006 IDLE: counter held at 0; rx_s==0 SHALL transition to START.
REQ-007 START: at counter==CLKS_PER_BIT/2-1 (integer divide), rx_s==0 SHALL go to DATA, counter 0, index 0; rx_s==1 (glitch) SHALL go to IDLE with no output activity.
REQ-008 DATA: at counter==CLKS_PER_BIT-1, the sampled bit SHALL shift into an internal shift register LSB first, the counter SHALL clear and the index SHALL increment; after the 8th bit the FSM SHALL go to STOP.
REQ-009 STOP: at counter==CLKS_PER_BIT-1, sampled 1 SHALL go to LOAD; sampled 0 SHALL pulse frame_err for exactly one cycle and go to BREAK.
REQ-010 BREAK SHALL wait for rx_s==1, then go to IDLE; no start bit is detected while in BREAK.
REQ-011 LOAD (1 cycle) SHALL register the shift register into byte_out; DONE (1 cycle) SHALL assert byte_end, then go to IDLE.
REQ-012 byte_out SHALL change only on the LOAD edge, SHALL be valid at least one cycle before byte_end rises, and SHALL hold through and after byte_end until the next valid frame. The downstream word assembler samples byte_out continuously and needs this.
REQ-013 byte_end SHALL be high for exactly one cycle per valid frame and SHALL never be high in two consecutive cycles.
REQ-014 A frame with a stop-bit error SHALL leave byte_out unchanged and SHALL NOT assert byte_end.
REQ-015 Latency SHALL be: byte_end high CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 4 cycles (±1) after the rx falling edge of the start bit.
REQ-016 A start bit arriving while in LOAD or DONE SHALL be detected no later than the first IDLE cycle. Back-to-back frames with a one-bit stop SHALL all be received.

Reset
REQ-017 reset SHALL force state IDLE, counter 0, index 0, shift register 0x00, byte_out 0x00, byte_end 0, frame_err 0, synchronizer flops 1.
REQ-018 reset asserted mid-frame SHALL abort the frame with no byte_end or frame_err. Reception SHALL resume with the next falling edge after reset deasserts.

Configuration
REQ-019 With macro UART_RX_MAJORITY_EN defined, every sample decision (start check, data bits, stop bit) SHALL use a 2-of-3 majority of rx_s at decision counter-2, -1 and 0. Without the macro, a single rx_s sample at the decision cycle SHALL be used. Port list and latency SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover these scenarios, using CLKS_PER_BIT=16:
- Scenario 1: send 0xA5 with a valid stop bit -> byte_out=0xA5 one cycle before a single-cycle byte_end, 156±1 cycles after the start edge; frame_err stays 0.
- Scenario 2: send 0x01, 0x3C, 0x02 back-to-back -> three byte_end pulses; byte_out reads 0x01, 0x3C, 0x02 in turn and is stable for ≥1 bit period around each pulse.
- Scenario 3: 4-cycle low glitch on idle rx -> no byte_end, no frame_err, FSM back in IDLE.
- Scenario 4: send 0x55 with stop bit 0, line low for 3 bit times, then send 0x0F -> one frame_err pulse, byte_out stays at its prior value, then byte_out=0x0F with byte_end.
- Scenario 5: reset pulsed during data bit 4 of 0xFF, then send 0x12 -> no pulse for the aborted frame; byte_out=0x12 with byte_end.
- Scenario 6 (UART_RX_MAJORITY_EN defined): send 0x81 with a 1-cycle inverted glitch at the centre of every bit -> byte_out=0x81, byte_end pulses, no frame_err.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer and a centre-sampling FSM.
// Define UART_RX_MAJORITY_EN to take each sample decision as a 2-of-3 vote over the last three rx_s samples.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_end,
  output logic       frame_err
);

  localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_LOAD  = 3'd4,
    S_DONE  = 3'd5,
    S_BREAK = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  r_byte_out;
  logic [7:0]  w_byte_nxt;
  logic        r_byte_end;
  logic        w_end_nxt;
  logic        r_frame_err;
  logic        w_err_nxt;
  logic        w_sample;

  // Two-flop synchronizer for the asynchronous serial line (idles high)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // r_hist[0] holds rx_s from one cycle back, r_hist[1] from two cycles back
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], r_rx_s};
    end
  end

  assign w_sample = maj3(r_rx_s, r_hist[0], r_hist[1]);
`else
  assign w_sample = r_rx_s;
`endif

  // Next-state and datapath decode; pulses default low so they last one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_byte_nxt  = r_byte_out;
    w_end_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 16'd0;
        w_idx_nxt = 3'd0;
        if (!r_rx_s) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt = 16'd0;
          w_idx_nxt = 3'd0;
          if (!w_sample) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = 16'd0;
          w_shift_nxt = {w_sample, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt = 16'd0;
          if (w_sample) begin
            // byte_out is updated on entry to LOAD, a full cycle ahead of byte_end
            w_byte_nxt  = r_shift;
            w_state_nxt = S_LOAD;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_LOAD: begin
        w_end_nxt   = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_BREAK: begin
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_BREAK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_byte_out  <= 8'h00;
      r_byte_end  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_out  <= w_byte_nxt;
      r_byte_end  <= w_end_nxt;
      r_frame_err <= w_err_nxt;
    end
  end

  assign byte_out  = r_byte_out;
  assign byte_end  = r_byte_end;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed, table-driven bench for uart_byte_rx at CLKS_PER_BIT=16.
// Frames are driven on the rx pin; outputs are sampled on the falling clock edge.
module tb_uart_byte_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] byte_out;
  logic       byte_end;
  logic       frame_err;

  uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .byte_out (byte_out),
    .byte_end (byte_end),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    int         extra_low;
    int         gap;
    logic [7:0] exp_byte;
    int         exp_end;
    int         exp_err;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_b[32];
  int n_exp = 0;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  int         n_end = 0;
  int         n_err = 0;
  int         n_post = 0;
  int         post_cnt = 0;
  int         end_cyc = 0;
  logic       prev_end = 1'b0;
  logic       prev_err = 1'b0;
  logic       dbl_end = 1'b0;
  logic       dbl_err = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] pulse_b[32];
  logic [7:0] pre_b[32];
  logic [7:0] post_b[32];

  // Output monitor: pulse counts, byte_out one cycle before and 16 cycles after each byte_end
  always @(negedge clk) begin
    prev_byte <= byte_out;
    prev_end  <= byte_end;
    prev_err  <= frame_err;
    if (byte_end && prev_end) dbl_end <= 1'b1;
    if (frame_err && prev_err) dbl_err <= 1'b1;
    if (frame_err) n_err <= n_err + 1;
    if (byte_end) begin
      if (n_end < 32) begin
        pulse_b[n_end] <= byte_out;
        pre_b[n_end]   <= prev_byte;
      end
      n_end    <= n_end + 1;
      end_cyc  <= cyc;
      post_cnt <= 16;
    end else if (post_cnt > 0) begin
      post_cnt <= post_cnt - 1;
      if (post_cnt == 1) begin
        if (n_post < 32) post_b[n_post] <= byte_out;
        n_post <= n_post + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    checks++;
    if (lat < 155 || lat > 157) begin
      errors++;
      $display("FAIL %s: actual latency %0d, required 155..157", name, lat);
    end
  endtask

  // Drive rx for n clocks; always returns 1 time unit after a rising edge
  task automatic hold(input logic v, input int n);
    rx = v;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v, input logic g);
    if (g) begin
      hold(v, 8);
      hold(~v, 1);
      hold(v, 7);
    end else begin
      hold(v, CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic g);
    start_cyc = cyc;
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(d[i], g);
    send_bit(stop, g);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int e0;
    int r0;
    e0 = n_end;
    r0 = n_err;
    send_frame(v.data, v.stop, v.glitch);
    if (v.extra_low > 0) hold(1'b0, v.extra_low * CPB);
    hold(1'b1, v.gap);
    check({name, "_end_cnt"}, n_end - e0, v.exp_end);
    check({name, "_err_cnt"}, n_err - r0, v.exp_err);
    check({name, "_byte_out"}, int'(byte_out), int'(v.exp_byte));
    if (v.exp_end == 1) begin
      check_lat({name, "_latency"}, end_cyc - start_cyc);
      check({name, "_pre_byte"}, int'(pre_b[n_end - 1]), int'(v.exp_byte));
      exp_b[n_exp] = int'(v.exp_byte);
      n_exp++;
    end
  endtask

  initial begin
    vec_t v;
    int e0;
    int r0;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0, 20, 8'hA5, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 0, 0,  8'h01, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 0, 0,  8'h3C, 1, 0};
    vecs[3] = '{8'h02, 1'b1, 1'b0, 0, 20, 8'h02, 1, 0};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 2, 20, 8'h02, 0, 1};
    vecs[5] = '{8'h0F, 1'b1, 1'b0, 0, 20, 8'h0F, 1, 0};
    vecs[6] = '{8'h00, 1'b1, 1'b0, 0, 5,  8'h00, 1, 0};
    vecs[7] = '{8'hFF, 1'b1, 1'b0, 0, 20, 8'hFF, 1, 0};

    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_byte_out", int'(byte_out), 0);
    check("reset_byte_end", int'(byte_end), 0);
    check("reset_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    hold(1'b1, 5);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Short low glitch on the idle line must be rejected; a real frame then follows
    e0 = n_end;
    r0 = n_err;
    hold(1'b0, 4);
    hold(1'b1, 60);
    check("glitch_end_cnt", n_end - e0, 0);
    check("glitch_err_cnt", n_err - r0, 0);
    v = '{8'h3C, 1'b1, 1'b0, 0, 20, 8'h3C, 1, 0};
    run_vec(v, "post_glitch");

    // Reset in the middle of data bit 4 of 0xFF aborts silently
    e0 = n_end;
    r0 = n_err;
    hold(1'b0, CPB);
    hold(1'b1, 4 * CPB + 8);
    reset = 1'b1;
    hold(1'b1, 2);
    reset = 1'b0;
    hold(1'b1, 6 * CPB);
    check("abort_end_cnt", n_end - e0, 0);
    check("abort_err_cnt", n_err - r0, 0);
    check("abort_byte_out", int'(byte_out), 0);
    v = '{8'h12, 1'b1, 1'b0, 0, 20, 8'h12, 1, 0};
    run_vec(v, "post_reset");

`ifdef UART_RX_MAJORITY_EN
    v = '{8'h81, 1'b1, 1'b1, 0, 20, 8'h81, 1, 0};
    run_vec(v, "majority");
`endif

    hold(1'b1, 24);
    check("total_end_cnt", n_end, n_exp);
    check("total_post_cnt", n_post, n_exp);
    check("byte_end_double", int'(dbl_end), 0);
    check("frame_err_double", int'(dbl_err), 0);
    for (int i = 0; i < n_exp && i < 32; i++) begin
      check($sformatf("pulse%0d_byte", i), int'(pulse_b[i]), exp_b[i]);
      check($sformatf("post%0d_byte", i), int'(post_b[i]), exp_b[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
